// File: rtl/alu_op_dispatch.sv
// Single-transaction dispatcher: issues one ALU command to one of eight asynchronous
// function units over a four-phase req/ack handshake and returns the muxed result.
module alu_op_dispatch #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [7:0]       unit_req,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  input  logic [7:0]       unit_ack,
  output logic [2:0]       unit_sel,
  input  logic [WIDTH-1:0] unit_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_op,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StReq, StRel, StResp} state_e;

  // tcnt reaches TIMEOUT-1 one cycle before this compare fires, so a phase that never
  // completes leaves its state TIMEOUT+1 cycles after entry.
  localparam logic [7:0] TLimit = 8'(TIMEOUT);

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic             sync1_q, ack_s_q;
  logic [7:0]       tcnt_q;

  logic accept, capture, req_expire, rel_expire, tmo;

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    capture    = 1'b0;
    req_expire = 1'b0;
    rel_expire = 1'b0;
    tmo        = (tcnt_q == TLimit);
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (ack_s_q) begin
          capture = 1'b1;
          state_d = StRel;
        end else if (tmo) begin
          req_expire = 1'b1;
          state_d    = StResp;
        end
      end
      StRel: begin
        if (!ack_s_q) begin
          state_d = StResp;
        end else if (tmo) begin
          rel_expire = 1'b1;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      sync1_q    <= 1'b0;
      ack_s_q    <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= cmd_op;
        a_q  <= cmd_a;
        b_q  <= cmd_b;
      end
      // Flush the synchronizer on accept so a stale ack from the previous unit
      // cannot be mistaken for the new unit's ack.
      if (accept) begin
        sync1_q <= 1'b0;
        ack_s_q <= 1'b0;
      end else begin
        sync1_q <= unit_ack[op_q];
        ack_s_q <= sync1_q;
      end
      if (state_d != state_q) begin
        tcnt_q <= '0;
      end else if (state_q == StReq || state_q == StRel) begin
        tcnt_q <= tcnt_q + 8'd1;
      end
      if (capture) begin
        rsp_data_q <= unit_result;
        rsp_err_q  <= 1'b0;
      end else if (req_expire) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b1;
      end else if (rel_expire) begin
        rsp_err_q <= 1'b1;
      end
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign unit_req  = (state_q == StReq) ? (8'b1 << op_q) : 8'b0;
  assign unit_sel  = op_q;
  assign unit_a    = a_q;
  assign unit_b    = b_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_op    = op_q;
  assign rsp_err   = rsp_err_q;

endmodule
